// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the alu_muldiv execute unit: ALU opcodes, RV32M funct3
// codes, FSM states and operand-signedness helpers.
package alu_muldiv_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic a_signed(input logic [2:0] op);
        return op inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM};
    endfunction

    function automatic logic b_signed(input logic [2:0] op);
        return op inside {M_MUL, M_MULH, M_DIV, M_REM};
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative core: unsigned shift-add multiply or restoring divide, one step
// per cycle on operand magnitudes; {hi,lo} holds product or {rem,quot}.
module alu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] mag_a,
    input  logic [XLEN-1:0] mag_b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] b_q;
    logic            div_q;
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            ge;

    assign add_sum = {1'b0, hi} + {1'b0, b_q};
    assign rem_sh  = {hi, lo[XLEN-1]};
    assign rem_sub = rem_sh - {1'b0, b_q};
    // hi < divisor always, so the borrow bit alone tells rem_sh < divisor
    assign ge      = ~rem_sub[XLEN];
    assign done    = (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else if (start) begin
            cnt   <= CW'(XLEN - 1);
            b_q   <= mag_b;
            div_q <= is_div;
            hi    <= '0;
            lo    <= mag_a;
        end else if (step) begin
            cnt <= cnt - 1'b1;
            if (div_q) begin
                if (ge) hi <= rem_sub[XLEN-1:0];
                else    hi <= rem_sh[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ge};
            end else if (lo[0]) begin
                {hi, lo} <= {add_sum, lo[XLEN-1:1]};
            end else begin
                {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU + RV32M unit with valid/ready handshake and flush.
// Define FAST_MUL_EN for a single-cycle multiplier; otherwise mul is iterative.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_m,
    input  logic [3:0]      alu_control,
    input  logic [2:0]      m_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    state_e state, state_nx;

    logic              accept, one_cycle, div_op, b_zero, ovf;
    logic              sgn_a, sgn_b, neg, neg_q, src_iter, core_done;
    logic [2:0]        m_op_q;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]   alu_res, quick_res, iter_res, result_q;
    logic [XLEN-1:0]   mag_a, mag_b, hi, lo;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY);

    assign shamt = op_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_control)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            default:  alu_res = '0;
        endcase
    end

    assign div_op = m_op[2];
    assign b_zero = (op_b == '0);
    assign ovf    = ((m_op == M_DIV) | (m_op == M_REM)) & (op_a == MIN_V) & (&op_b);
    assign sgn_a  = a_signed(m_op) & op_a[XLEN-1];
    assign sgn_b  = b_signed(m_op) & op_b[XLEN-1];
    assign mag_a  = sgn_a ? -op_a : op_a;
    assign mag_b  = sgn_b ? -op_b : op_b;
    // remainders follow the dividend; quotients and products follow a^b
    assign neg    = (m_op[2] & m_op[1]) ? sgn_a : (sgn_a ^ sgn_b);

`ifdef FAST_MUL_EN
    logic signed [XLEN:0]     fa, fb;
    logic signed [2*XLEN+1:0] fp;
    logic [XLEN-1:0]          mul_res;

    assign fa      = {a_signed(m_op) & op_a[XLEN-1], op_a};
    assign fb      = {b_signed(m_op) & op_b[XLEN-1], op_b};
    assign fp      = fa * fb;
    assign mul_res = (m_op == M_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`endif

    always_comb begin
        one_cycle = 1'b1;
        quick_res = alu_res;
        if (is_m) begin
            if (div_op & b_zero)
                quick_res = m_op[1] ? op_a : '1;
            else if (ovf)
                quick_res = m_op[1] ? '0 : MIN_V;
`ifdef FAST_MUL_EN
            else if (!div_op)
                quick_res = mul_res;
`endif
            else
                one_cycle = 1'b0;
        end
    end

    assign prod     = {hi, lo};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        iter_res = '0;
        case (m_op_q)
            M_MUL:                    iter_res = prod_fix[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: iter_res = prod_fix[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:            iter_res = neg_q ? -lo : lo;
            default:                  iter_res = neg_q ? -hi : hi;
        endcase
    end

    assign result = src_iter ? iter_res : result_q;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = one_cycle ? S_DONE : S_BUSY;
            S_BUSY: if (core_done) state_nx = S_DONE;
            S_DONE: begin
                if (accept)         state_nx = one_cycle ? S_DONE : S_BUSY;
                else if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            result_q <= '0;
            src_iter <= 1'b0;
            m_op_q   <= M_MUL;
            neg_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                result_q <= quick_res;
                src_iter <= ~one_cycle;
                m_op_q   <= m_op;
                neg_q    <= neg;
            end
        end
    end

    alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept & ~one_cycle),
        .step   (state == S_BUSY),
        .is_div (div_op),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .done   (core_done),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed cases plus random ops against
// an arithmetic reference model. Honours FAST_MUL_EN for mul latency.
module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, is_m;
    logic        out_valid, out_ready, busy;
    logic [3:0]  alu_control;
    logic [2:0]  m_op;
    logic [31:0] op_a, op_b, result;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_m        (is_m),
        .alu_control (alu_control),
        .m_op        (m_op),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input bit m, input logic [3:0] ctl,
                                          input logic [2:0] mop,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        if (!m) begin
            case (ctl)
                ALU_ADD:  return a + b;
                ALU_SUB:  return a - b;
                ALU_SLL:  return a << b[4:0];
                ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
                ALU_XOR:  return a ^ b;
                ALU_SRL:  return a >> b[4:0];
                ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
                ALU_OR:   return a | b;
                ALU_AND:  return a & b;
                default:  return 32'd0;
            endcase
        end
        case (mop)
            M_MUL:    begin p = sa * sb; return p[31:0];  end
            M_MULH:   begin p = sa * sb; return p[63:32]; end
            M_MULHSU: begin p = sa * ub; return p[63:32]; end
            M_MULHU:  begin p = ua * ub; return p[63:32]; end
            M_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            M_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            M_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // extra edges after the accept edge until out_valid is seen
    function automatic int lat_of(input bit m, input logic [2:0] mop,
                                  input logic [31:0] a, input logic [31:0] b);
        if (!m) return 0;
        if (mop[2]) begin
            if (b == 0) return 0;
            if ((mop == M_DIV || mop == M_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 0;
            return 32;
        end
`ifdef FAST_MUL_EN
        return 0;
`else
        return 32;
`endif
    endfunction

    task automatic run_op(input string tag, input bit m, input logic [3:0] ctl,
                          input logic [2:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat);
        int lat;
        chk({tag, " in_ready"}, in_ready, 1);
        is_m = m; alu_control = ctl; m_op = mop; op_a = a; op_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(tag, result, exp);
        chk({tag, " latency"}, lat, exp_lat);
        @(posedge clk); #1;
    endtask

    task automatic start_divu(input logic [31:0] a, input logic [31:0] b);
        is_m = 1'b1; m_op = M_DIVU; op_a = a; op_b = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  mop;
        logic [31:0] a, b, exp;
    } mvec_t;

    mvec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [31:0] a, b;
        bit m;
        logic [3:0] ctl;
        logic [2:0] mop;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        is_m = 1'b0; alu_control = ALU_ADD; m_op = M_MUL; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset result", result, 0);
        chk("reset busy", busy, 0);
        rst_n = 1'b1;

        // back-to-back ALU stream, one result per cycle
        is_m = 1'b0; in_valid = 1'b1;
        alu_control = ALU_ADD; op_a = 5; op_b = 7;
        @(posedge clk); #1;
        chk("stream add valid", out_valid, 1);
        chk("stream add", result, 32'd12);
        chk("stream in_ready", in_ready, 1);
        alu_control = ALU_SUB; op_a = 3; op_b = 5;
        @(posedge clk); #1;
        chk("stream sub valid", out_valid, 1);
        chk("stream sub", result, 32'hFFFF_FFFE);
        alu_control = ALU_SRA; op_a = 32'h8000_0000; op_b = 4;
        @(posedge clk); #1;
        chk("stream sra valid", out_valid, 1);
        chk("stream sra", result, 32'hF800_0000);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream drained", out_valid, 0);

        vecs = '{
            '{M_MULH,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
            '{M_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{M_DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
            '{M_REM,   32'd7,         32'hFFFF_FFFE, 32'd1},
            '{M_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
            '{M_DIVU,  32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF},
            '{M_DIV,   32'd1234,      32'd0,         32'hFFFF_FFFF},
            '{M_REMU,  32'd9,         32'd0,         32'd9},
            '{M_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{M_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0}
        };
        foreach (vecs[i])
            run_op($sformatf("directed m_op=%0d #%0d", vecs[i].mop, i), 1'b1, ALU_ADD,
                   vecs[i].mop, vecs[i].a, vecs[i].b, vecs[i].exp,
                   lat_of(1'b1, vecs[i].mop, vecs[i].a, vecs[i].b));

        // back-pressure on a finished divide
        out_ready = 1'b0;
        start_divu(32'hFFFF_FFFF, 32'd2);
        begin
            int lat;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("bp latency", lat, 32);
        end
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp result", result, 32'h7FFF_FFFF);
            chk("bp out_valid", out_valid, 1);
            chk("bp in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp single transfer", out_valid, 0);

        // flush at the tenth BUSY cycle
        start_divu(32'd100, 32'd7);
        chk("flush busy", busy, 1);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy cleared", busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("flush no result", seen, 0);
        run_op("after flush add", 1'b0, ALU_ADD, M_MUL, 1, 1, 2, 0);

        // op presented together with flush is dropped
        is_m = 1'b0; alu_control = ALU_ADD; op_a = 3; op_b = 4;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush blocks accept", out_valid, 0);

        // synchronous reset mid-divide
        start_divu(32'd1000, 32'd3);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset result", result, 0);
        chk("midreset in_ready", in_ready, 1);
        chk("midreset busy", busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("midreset no result", seen, 0);
        run_op("after reset add", 1'b0, ALU_ADD, M_MUL, 1, 1, 2, 0);

        // random ops against the reference model
        for (int i = 0; i < 60; i++) begin
            m   = 1'($urandom_range(0, 1));
            ctl = 4'($urandom_range(0, 11));
            mop = 3'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            run_op($sformatf("rand #%0d m=%0d ctl=%0d mop=%0d a=%h b=%h", i, m, ctl, mop, a, b),
                   m, ctl, mop, a, b, model(m, ctl, mop, a, b), lat_of(m, mop, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
